alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares a single combinational ALU (codes: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, other = pass a) between two requesters in the pipeline, e.g. the EX-stage issue port and the branch/compare port. It arbitrates, latches the winner's operands, drives the external ALU for one cycle, and registers the result. The result is held on a valid/ready response channel tagged with requester ID and a caller tag.

## Interface
- WIDTH, 32, operand/result width
- TAG_W, 4, caller tag width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  4  ALU_control code
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_tag / req1_tag  in  TAG_W  caller tag, returned unchanged
- alu_control  out  4  to ALU
- alu_a, alu_b  out  WIDTH  to ALU
- alu_result  in  WIDTH  from ALU
- alu_zero  in  1  from ALU
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  winning requester (0/1)
- rsp_tag  out  TAG_W  tag of the completed request
- rsp_result  out  WIDTH  captured ALU result
- rsp_zero  out  1  captured zero flag

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE arbitration (combinational from the valids):
  - Only one requester valid: it wins.
  - Both valid: the requester selected by the round-robin pointer `rr` wins.
  - `req<i>_ready = (state==IDLE) && grant_i`. At most one ready is high in any cycle.
- On the handshake (valid && ready):
  - Latch op, a, b, tag, and the winner ID into the operand registers.
  - Set `rr` to the loser; `rr` then favours the other requester next time.
  - Go to EXEC.
- EXEC (one cycle): the ALU sees the latched operands. At the end of the cycle, capture `alu_result` into `rsp_result` and `alu_zero` into `rsp_zero`, then go to RESP.
- RESP:
  - `rsp_valid=1`.
  - On `rsp_ready=1`, go to IDLE.
  - Otherwise hold every `rsp_*` output stable.
- `alu_control`, `alu_a` and `alu_b` are driven from the operand registers in every state. The ALU input changes only on a request handshake.
- Inputs are sampled only at the handshake. Requester inputs may change freely at any other time.

## Timing
- Reset values:
  - `rsp_valid=0`, `rsp_id=0`, `rsp_tag=0`, `rsp_result=0`, `rsp_zero=0`.
  - `alu_control=0000`, `alu_a=0`, `alu_b=0`.
  - `rr=0`, so requester 0 wins the first tie.
- Latency: handshake at edge N → result captured at edge N+1 → `rsp_valid` high during cycle N+1..N+2, visible immediately after edge N+1.
- Peak throughput: one operation per 3 cycles, achieved with `rsp_ready` tied high.
- `req_ready` is low throughout EXEC and RESP. A request arriving then waits; it is not dropped.
- Simultaneous valids in IDLE: exactly one is granted. The other stays pending and wins the next IDLE cycle if it is still valid (round-robin).
- `rsp_ready` high while `rsp_valid` is low has no effect.
- Reset asserted mid-operation (EXEC or RESP):
  - Immediately: state → IDLE, `rsp_valid=0`, all registers to their reset values.
  - The in-flight operation is discarded and no response is produced.
- Width rules:
  - The ALU computes at full WIDTH and overflow wraps.
  - slt compares unsigned, as the ALU does. The controller passes results through untouched.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined:
  - Requester 0 always wins a tie.
  - `rr` is not implemented.
  - Requester 1 is served only when `req0_valid=0` in IDLE.
- Not defined: round-robin as described in Operation.

## Test plan
- Single request: req0 op=0010, a=5, b=7, tag=3, `rsp_ready=1` → `req0_ready` at N; at N+1 `rsp_valid=1`, `rsp_result=12`, `rsp_zero=0`, `rsp_id=0`, `rsp_tag=3`.
- Zero flag and wrap: req1 op=0110, a=9, b=9 → `rsp_result=0`, `rsp_zero=1`, `rsp_id=1`. Then op=0010, a=FFFFFFFF, b=1 → `rsp_result=0`, `rsp_zero=1`.
- Tie, round-robin: both valid continuously after reset → grants in order 0, 1, 0, 1. With `ALU_ARB_FIXED_PRIO_EN` → 0, 0, 0, 0.
- Backpressure: `rsp_ready=0` for 5 cycles in RESP with op=0111, a=2, b=3 → `rsp_result=1` held stable, both `req_ready` low; `rsp_ready=1` → IDLE next cycle.
- Reset mid-EXEC: handshake at N, assert reset during cycle N+1 → `rsp_valid` stays 0, all outputs are at reset values, and a fresh request completes normally afterwards.
- Default opcode: op=1111, a=ABCD0123, b=0 → `rsp_result=ABCD0123` (pass-through a), and `alu_control=1111` during EXEC.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external combinational ALU between two requesters. A winner is
// picked in IDLE, its operands are latched, the ALU is driven from those
// registers for one cycle, and the result is registered and held on a
// valid/ready response channel tagged with requester ID and caller tag.
//
// Ports
//   clk                    clock, rising edge
//   reset                  asynchronous, active-high
//   req<i>_valid/_ready    request handshake, i = 0,1
//   req<i>_op/_a/_b/_tag   ALU code, operands, caller tag
//   alu_control/_a/_b      to external ALU (from operand registers)
//   alu_result/_zero       from external ALU
//   rsp_valid/_ready       response handshake
//   rsp_id/_tag/_result/_zero  completed request's ID, tag, result, zero flag
//
// Configuration macro: ALU_ARB_FIXED_PRIO_EN
//   defined   -> requester 0 always wins a tie, no round-robin pointer
//   undefined -> round-robin between simultaneous requests
//
// state | meaning
// IDLE  | waiting for a request; ready asserted for the granted requester
// EXEC  | latched operands on the ALU; result captured at end of cycle
// RESP  | response held valid until rsp_ready

module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_nxt;
  logic               grant0, grant1;
  logic               hs;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [TAG_W-1:0]   tag_q;
  logic               id_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant0 = req0_valid;
  assign grant1 = req1_valid & ~req0_valid;
`else
  // rr names the requester favoured on the next tie.
  logic rr;

  assign grant0 = req0_valid & (~req1_valid | ~rr);
  assign grant1 = req1_valid & (~req0_valid | rr);

  // After any grant the pointer moves to the loser, i.e. the other requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr <= 1'b0;
    else if (hs)
      rr <= grant0;
  end
`endif

  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign hs         = req0_ready | req1_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      if (hs) begin
        op_q  <= grant1 ? req1_op  : req0_op;
        a_q   <= grant1 ? req1_a   : req0_a;
        b_q   <= grant1 ? req1_b   : req0_b;
        tag_q <= grant1 ? req1_tag : req0_tag;
        id_q  <= grant1;
      end
      if (state == EXEC) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
      end
    end
  end

  // Operand registers only change on a handshake, so ID and tag stay
  // stable for the whole response without separate copies.
  assign alu_control = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign rsp_valid   = (state == RESP);
  assign rsp_id      = id_q;
  assign rsp_tag     = tag_q;
  assign rsp_result  = result_q;
  assign rsp_zero    = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [3:0]       req0_op = '0, req1_op = '0;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic             alu_zero;
  logic             rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zero;
  logic [TAG_W-1:0] rsp_tag;
  logic [WIDTH-1:0] rsp_result;

  int checks = 0;
  int failures = 0;
  bit last_win = 1'b1;  // requester served most recently; 1 after reset so 0 wins first tie

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  function automatic logic [WIDTH-1:0] ref_alu(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (a < b) ? WIDTH'(1) : WIDTH'(0);
      default: return a;
    endcase
  endfunction

  // External ALU stand-in
  always_comb begin
    alu_result = ref_alu(alu_control, alu_a, alu_b);
    alu_zero   = (alu_result == '0);
  end

  function automatic bit model_winner(input bit v0, input bit v1);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return v0 ? 1'b0 : 1'b1;
`else
    if (v0 && v1) return ~last_win;
    return v1;
`endif
  endfunction

  // One request through the full cycle: arbitration, EXEC, RESP with `hold`
  // backpressure cycles, return to IDLE. Called with the DUT in IDLE.
  task automatic do_op(input string name, input bit v0, input bit v1,
                       input logic [3:0] op0, input logic [WIDTH-1:0] a0,
                       input logic [WIDTH-1:0] b0, input logic [TAG_W-1:0] t0,
                       input logic [3:0] op1, input logic [WIDTH-1:0] a1,
                       input logic [WIDTH-1:0] b1, input logic [TAG_W-1:0] t1,
                       input int hold);
    bit w;
    logic [3:0] e_op;
    logic [WIDTH-1:0] e_a, e_b, e_res;
    logic [TAG_W-1:0] e_tag;
    @(negedge clk);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0; req0_tag = t0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1; req1_tag = t1;
    rsp_ready = 1'b0;
    w = model_winner(v0, v1);
    e_op = w ? op1 : op0; e_a = w ? a1 : a0; e_b = w ? b1 : b0; e_tag = w ? t1 : t0;
    e_res = ref_alu(e_op, e_a, e_b);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== (w ? 2'b10 : 2'b01)) begin
      failures++;
      $display("FAIL %s grant: ready1/0=%b%b required winner=%0d", name, req1_ready, req0_ready, w);
    end
    @(posedge clk); #1;
    last_win = w;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    req0_valid = 1'($urandom); req1_valid = 1'($urandom); rsp_ready = 1'($urandom);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || alu_control !== e_op || alu_a !== e_a || alu_b !== e_b ||
        req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s exec: valid=%b ctl=%h a=%h b=%h rdy=%b%b required valid=0 ctl=%h a=%h b=%h rdy=00",
               name, rsp_valid, alu_control, alu_a, alu_b, req1_ready, req0_ready, e_op, e_a, e_b);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'($urandom); req1_valid = 1'($urandom);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== w || rsp_tag !== e_tag || rsp_result !== e_res ||
        rsp_zero !== (e_res == '0) || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s resp: valid=%b id=%b tag=%h res=%h zero=%b rdy=%b%b required 1 %b %h %h %b 00",
               name, rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_zero, req1_ready, req0_ready,
               w, e_tag, e_res, (e_res == '0));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== w || rsp_tag !== e_tag || rsp_result !== e_res ||
          alu_control !== e_op || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s hold%0d: valid=%b id=%b tag=%h res=%h ctl=%h rdy=%b%b required 1 %b %h %h %h 00",
                 name, i, rsp_valid, rsp_id, rsp_tag, rsp_result, alu_control,
                 req1_ready, req0_ready, w, e_tag, e_res, e_op);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s release: rsp_valid=%b required 0", name, rsp_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_tag !== '0 || rsp_result !== '0 ||
        rsp_zero !== 1'b0 || alu_control !== 4'b0 || alu_a !== '0 || alu_b !== '0) begin
      failures++;
      $display("FAIL reset_values: valid=%b id=%b tag=%h res=%h zero=%b ctl=%h a=%h b=%h required all 0",
               rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_zero, alu_control, alu_a, alu_b);
    end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: rdy=%b%b valid=%b required 000", req1_ready, req0_ready, rsp_valid);
    end
    last_win = 1'b1;
  endtask

  task automatic test_single();
    do_op("single", 1, 0, 4'b0010, 5, 7, 3, 4'b0, 0, 0, 0, 0);
  endtask

  task automatic test_zero_wrap();
    do_op("sub_zero", 0, 1, 4'b0, 0, 0, 0, 4'b0110, 9, 9, 4'h5, 0);
    do_op("add_wrap", 0, 1, 4'b0, 0, 0, 0, 4'b0010, 32'hFFFF_FFFF, 1, 4'h6, 1);
  endtask

  task automatic test_backpressure();
    do_op("backpressure", 1, 0, 4'b0111, 2, 3, 4'h2, 4'b0, 0, 0, 0, 5);
  endtask

  task automatic test_default_op();
    do_op("pass_a", 1, 0, 4'b1111, 32'hABCD_0123, 0, 4'hA, 4'b0, 0, 0, 0, 1);
  endtask

  task automatic test_tie();
    bit exp;
    bit got;
    int n;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    last_win = 1'b1;
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 1; req0_b = 1; req0_tag = 4'h0;
    req1_valid = 1'b1; req1_op = 4'b0001; req1_a = 2; req1_b = 4; req1_tag = 4'h1;
    rsp_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      exp = model_winner(1, 1);
      n = 0;
      while (n < 10) begin
        #1;
        if (req0_ready || req1_ready) break;
        @(negedge clk);
        n++;
      end
      got = req1_ready;
      checks++;
      if (n == 10 || (req0_ready && req1_ready) || got !== exp) begin
        failures++;
        $display("FAIL tie_grant%0d: rdy=%b%b waited=%0d required winner=%0d", g, req1_ready, req0_ready, n, exp);
      end
      last_win = exp;
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 10; req0_b = 20; req0_tag = 4'h9;
    req1_valid = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_exec_grant: req0_ready=%b required 1", req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_tag !== '0 || rsp_result !== '0 ||
        rsp_zero !== 1'b0 || alu_control !== 4'b0 || alu_a !== '0 || alu_b !== '0) begin
      failures++;
      $display("FAIL rst_exec_values: valid=%b id=%b tag=%h res=%h zero=%b ctl=%h a=%h b=%h required all 0",
               rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_zero, alu_control, alu_a, alu_b);
    end
    @(negedge clk); reset = 1'b0;
    last_win = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_exec_norsp%0d: rsp_valid=%b required 0", i, rsp_valid);
      end
    end
    do_op("after_reset", 1, 1, 4'b0110, 100, 1, 4'h4, 4'b0000, 32'hF0F0, 32'hFF00, 4'h8, 0);
  endtask

  task automatic test_random();
    logic [3:0] ops [7];
    bit v0, v1;
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110;
    ops[4] = 4'b0111; ops[5] = 4'b1111; ops[6] = 4'b0101;
    for (int k = 0; k < 40; k++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v1 = 1'b1;
      do_op("random", v0, v1,
            ops[$urandom_range(0, 6)], $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
            4'($urandom),
            ops[$urandom_range(0, 6)], $urandom, $urandom_range(0, 40), 4'($urandom),
            $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_wrap();
    test_tie();
    test_backpressure();
    test_reset_mid_exec();
    test_default_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
